// File: rtl/input_conditioner_if.sv
// ---------------------------------------------------------------------------
// input_conditioner_if
//   Groups the signals between the switch inputs, the conditioner and the
//   FSM that consumes the conditioned levels.
//
//   raw_a..raw_d : asynchronous, bouncy switch/button levels
//   A..D         : debounced, synchronized levels (registered)
//   rise[3:0]    : one-cycle pulse per channel {A,B,C,D} on a 0->1 change
//   fall[3:0]    : one-cycle pulse per channel {A,B,C,D} on a 1->0 change
//   any_change   : OR of all rise and fall bits
//
//   The interface carries no handshake. The conditioned levels and pulses
//   are plain registered outputs that are valid every cycle.
//
//   modport master : the environment side (drives raw, observes outputs)
//   modport slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface input_conditioner_if;
    logic       raw_a;
    logic       raw_b;
    logic       raw_c;
    logic       raw_d;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any_change;

    modport master (
        output raw_a, raw_b, raw_c, raw_d,
        input  A, B, C, D, rise, fall, any_change
    );

    modport slave (
        input  raw_a, raw_b, raw_c, raw_d,
        output A, B, C, D, rise, fall, any_change
    );
endinterface

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//   Four independent, identical channels. Each channel does the following:
//   two-flop synchronizer -> debounce counter -> registered level, plus
//   registered rise/fall pulses.
//
//   A conditioned level changes only after the synchronized input has
//   differed from it on DEBOUNCE_CYCLES consecutive clock edges. Any return
//   to the current level restarts the count.
//
//   Parameters
//     DEBOUNCE_CYCLES : consecutive differing edges before a change (2..65535)
//     CNT_W           : width of the per-channel debounce counter
//
//   Ports
//     clk   : system clock; all state updates on its rising edge
//     reset : synchronous, active-high reset
//     bus   : input_conditioner_if.slave (raw inputs, levels, pulses)
// ---------------------------------------------------------------------------
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input_conditioner_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order everywhere is {A,B,C,D}: bit 3 = A, bit 0 = D.
    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] out_q;
    logic [3:0] rise_q;
    logic [3:0] fall_q;

    assign raw = {bus.raw_a, bus.raw_b, bus.raw_c, bus.raw_d};

    // Two-flop synchronizer. The raw inputs touch nothing else.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic [CNT_W-1:0] cnt;
        logic             out_r;
        logic             rise_r;
        logic             fall_r;

        always_ff @(posedge clk) begin
            if (reset) begin
                // A partial count is discarded. Dropping out to 0 here
                // does not create a fall pulse.
                cnt    <= '0;
                out_r  <= 1'b0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                if (sync2[i] == out_r) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    // This is the last differing edge. Update the level and
                    // emit a pulse that lines up with the new level.
                    cnt    <= '0;
                    out_r  <= sync2[i];
                    rise_r <= sync2[i];
                    fall_r <= ~sync2[i];
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign out_q[i]  = out_r;
        assign rise_q[i] = rise_r;
        assign fall_q[i] = fall_r;
    end

    assign bus.A          = out_q[3];
    assign bus.B          = out_q[2];
    assign bus.C          = out_q[1];
    assign bus.D          = out_q[0];
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.any_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//   Testbench for input_conditioner, configured with DEBOUNCE_CYCLES = 4.
//
//   The reference model treats each channel as a two-sample-delayed copy of
//   the raw input. It keeps a history of those delayed samples. A level flips
//   when the newest DEBOUNCE_CYCLES samples all differ from the current level.
//
//   The bench runs directed scenarios first (clean step, release,
//   simultaneous, bounce, reset mid-count, short glitch) and then randomized
//   traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int DC = 4;
    localparam logic [15:0] MASK = 16'((1 << DC) - 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    input_conditioner_if bus ();

    input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] raw = 4'b0000;   // {a,b,c,d}
    assign bus.raw_a = raw[3];
    assign bus.raw_b = raw[2];
    assign bus.raw_c = raw[1];
    assign bus.raw_d = raw[0];

    // ---------------- reference model state ----------------
    logic [3:0]  m_s1   = '0;
    logic [3:0]  m_s2   = '0;
    logic [3:0]  m_out  = '0;
    logic [3:0]  m_rise = '0;
    logic [3:0]  m_fall = '0;
    logic [15:0] m_hist [4];

    int checks = 0;
    int errors = 0;

    function automatic logic [3:0] dut_out();
        return {bus.A, bus.B, bus.C, bus.D};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge: advance the model with the pre-edge inputs, then
    // compare all outputs just after the edge.
    task automatic step();
        logic flip;
        @(posedge clk);
        if (reset) begin
            m_s1   = '0;
            m_s2   = '0;
            m_out  = '0;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < 4; c++) m_hist[c] = '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_hist[c] = {m_hist[c][14:0], m_s2[c]};
                flip = ((m_hist[c] ^ {16{~m_out[c]}}) & MASK) == 16'h0;
                m_rise[c] = flip && !m_out[c];
                m_fall[c] = flip && m_out[c];
                if (flip) m_out[c] = ~m_out[c];
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
        #1;
        chk("model_out",        dut_out(),            m_out);
        chk("model_rise",       bus.rise,             m_rise);
        chk("model_fall",       bus.fall,             m_fall);
        chk("model_any_change", bus.any_change,       |(m_rise | m_fall));
        chk("rise_fall_excl",   bus.rise & bus.fall,  4'b0000);
    endtask

    // Call this right after raw changed on the channels in mask. The new
    // level must appear exactly DC+1 edges after the sampling edge, with a
    // single pulse.
    task automatic expect_change(input logic [3:0] mask, input logic lvl, input string tag);
        logic [3:0] want;
        want = lvl ? mask : 4'b0000;
        for (int k = 1; k <= DC + 2; k++) begin
            step();
            if (k < DC + 2) begin
                chk({tag, "_hold"},       dut_out() & mask,        ~want & mask);
                chk({tag, "_hold_pulse"}, (bus.rise | bus.fall) & mask, 4'b0000);
            end else begin
                chk({tag, "_level"}, dut_out() & mask,          want);
                chk({tag, "_pulse"}, lvl ? bus.rise : bus.fall, mask);
                chk({tag, "_other"}, lvl ? bus.fall : bus.rise, 4'b0000);
                chk({tag, "_any"},   bus.any_change,            1'b1);
            end
        end
        step();
        chk({tag, "_pulse_end"}, (bus.rise | bus.fall) & mask, 4'b0000);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        for (int c = 0; c < 4; c++) m_hist[c] = '0;

        // Reset state
        reset = 1'b1;
        step();
        step();
        chk("reset_out",  dut_out(),      4'b0000);
        chk("reset_rise", bus.rise,       4'b0000);
        chk("reset_fall", bus.fall,       4'b0000);
        chk("reset_any",  bus.any_change, 1'b0);
        reset = 1'b0;
        repeat (3) step();

        // Clean step on A
        raw[3] = 1'b1;
        expect_change(4'b1000, 1'b1, "clean_a");

        // Bring C high, then release it
        raw[1] = 1'b1;
        expect_change(4'b0010, 1'b1, "c_up");
        raw[1] = 1'b0;
        expect_change(4'b0010, 1'b0, "release_c");

        // A back low, then A and D rise together
        raw[3] = 1'b0;
        expect_change(4'b1000, 1'b0, "a_down");
        raw = raw | 4'b1001;
        expect_change(4'b1001, 1'b1, "simul_ad");

        // Bounce on B: high 3 edges, low 1, then steady high
        raw[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bounce_hold", dut_out() & 4'b0100, 4'b0000);
            chk("bounce_quiet", (bus.rise | bus.fall) & 4'b0100, 4'b0000);
        end
        raw[2] = 1'b0;
        step();
        chk("bounce_hold", dut_out() & 4'b0100, 4'b0000);
        raw[2] = 1'b1;
        expect_change(4'b0100, 1'b1, "bounce_b");

        // Reset while A,B,D are high: no fall pulses
        raw = 4'b0000;
        reset = 1'b1;
        step();
        chk("rst_hi_out",  dut_out(),      4'b0000);
        chk("rst_hi_fall", bus.fall,       4'b0000);
        chk("rst_hi_any",  bus.any_change, 1'b0);
        reset = 1'b0;
        repeat (2) step();

        // Reset in the middle of a B debounce
        raw[2] = 1'b1;
        repeat (4) step();
        chk("mid_hold", dut_out(), 4'b0000);
        reset = 1'b1;
        step();
        chk("mid_rst_out",  dut_out(), 4'b0000);
        chk("mid_rst_fall", bus.fall,  4'b0000);
        reset = 1'b0;
        expect_change(4'b0100, 1'b1, "post_reset_b");

        // Single-edge glitch on D
        raw[0] = 1'b1;
        step();
        raw[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("glitch_d",     dut_out() & 4'b0001, 4'b0000);
            chk("glitch_pulse", bus.rise | bus.fall, 4'b0000);
            chk("glitch_any",   bus.any_change,      1'b0);
        end

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 80) == 0);
            if ($urandom_range(0, 3) == 0) raw = 4'($urandom);
            step();
        end
        reset = 1'b0;
        repeat (DC + 4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
